// File: rtl/kt8_pkg.sv
// Shared definitions for the kt8 data-side serial port: address map,
// status byte layout and TX state encodings.
package kt8_pkg;

  localparam logic [7:0] KT8_TX_ADDR   = 8'hF0;
  localparam logic [7:0] KT8_STAT_ADDR = 8'hF1;

  localparam int STAT_EMPTY_BIT  = 0;
  localparam int STAT_FULL_BIT   = 1;
  localparam int STAT_ACTIVE_BIT = 2;
  localparam int STAT_OVF_BIT    = 3;
  localparam int STAT_COUNT_LSB  = 4;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_START = 2'b01;
  localparam logic [1:0] ST_DATA  = 2'b10;
  localparam logic [1:0] ST_STOP  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } tx_state_t;

  function automatic logic [7:0] pack_status(input logic       empty,
                                             input logic       full,
                                             input logic       active,
                                             input logic       ovf,
                                             input logic [2:0] count);
    logic [7:0] s;
    s = '0;
    s[STAT_EMPTY_BIT]          = empty;
    s[STAT_FULL_BIT]           = full;
    s[STAT_ACTIVE_BIT]         = active;
    s[STAT_OVF_BIT]            = ovf;
    s[STAT_COUNT_LSB +: 3]     = count;
    return s;
  endfunction

endpackage

// File: rtl/kt8_byte_fifo.sv
// Small circular byte FIFO with a count register; clear is a synchronous
// flush that wins over push and pop.
module kt8_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [2:0] count,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count == 3'(DEPTH));
  assign empty = (count == 3'd0);
  assign dout  = mem[rd_ptr];

  // When full, a push is still accepted if the head leaves the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/kt8_uart_tx_port.sv
// kt8 data-side bus decoder: routes CPU writes to RAM or to a memory-mapped
// 8N1 transmitter with a TX FIFO and a readable status register.
module kt8_uart_tx_port
  import kt8_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] TX_ADDR      = KT8_TX_ADDR,
  parameter logic [7:0] STAT_ADDR    = KT8_STAT_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_address,
  input  logic [7:0] ram_out,
  input  logic       write,
  input  logic       kd_reset,
  input  logic [7:0] mem_rdata,
  output logic [7:0] ram_in,
  output logic       mem_write,
  output logic       tx,
  output logic       tx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic       tx_sel;
  logic       stat_sel;
  logic       push_req;
  logic       stat_wr;
  logic       drop;
  logic       overflow;
  logic [7:0] status;

  logic       fifo_pop;
  logic [7:0] fifo_dout;
  logic [2:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_done;

  assign tx_sel    = (data_address == TX_ADDR);
  assign stat_sel  = (data_address == STAT_ADDR);
  assign mem_write = write && !(tx_sel || stat_sel);
  assign push_req  = write && tx_sel;
  assign stat_wr   = write && stat_sel;
  assign drop      = push_req && fifo_full && !fifo_pop;

  assign status = pack_status(fifo_empty, fifo_full, state_q != IDLE,
                              overflow, fifo_count);

  always_comb begin
    ram_in = mem_rdata;
    if (stat_sel)    ram_in = status;
    else if (tx_sel) ram_in = 8'h00;
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE) || (fifo_count != 3'd0);

  kt8_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (kd_reset),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (ram_out),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A drop in the same cycle as a clear leaves the sticky flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           overflow <= 1'b0;
    else if (kd_reset) overflow <= 1'b0;
    else if (drop)     overflow <= 1'b1;
    else if (stat_wr)  overflow <= 1'b0;
  end

  assign bit_done = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // tx_d is the line level for the next cycle, so tx is glitch-free.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          cnt_d    = '0;
          state_d  = START;
          tx_d     = 1'b0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_d[0];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else if (kd_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_kt8_uart_tx_port.sv
// Bench for kt8_uart_tx_port: serial monitor checks frames against a queue
// of expected bytes; scenario tasks check decode, status and timing.
module tb_kt8_uart_tx_port;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_address;
  logic [7:0] ram_out;
  logic       write;
  logic       kd_reset;
  logic [7:0] mem_rdata;
  logic [7:0] ram_in;
  logic       mem_write;
  logic       tx;
  logic       tx_busy;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b1;

  kt8_uart_tx_port #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .TX_ADDR      (8'hF0),
    .STAT_ADDR    (8'hF1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_address (data_address),
    .ram_out      (ram_out),
    .write        (write),
    .kd_reset     (kd_reset),
    .mem_rdata    (mem_rdata),
    .ram_in       (ram_in),
    .mem_write    (mem_write),
    .tx           (tx),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Serial receiver: samples mid-bit and pops the expected byte per frame.
  initial begin : monitor
    logic [7:0] rx;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      while (mon_en && !rst && tx === 1'b0) begin
        repeat (2) @(negedge clk);
        vectors++;
        if (tx !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL start_bit: got %b required 0", tx);
        end
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        vectors++;
        if (tx !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL stop_bit: got %b required 1", tx);
        end
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_frame: got %h required none", rx);
        end else begin
          exp_b = exp_q.pop_front();
          if (rx !== exp_b) begin
            miscompares++;
            $display("[TB] FAIL frame_data: got %h required %h", rx, exp_b);
          end
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (tx !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL idle_gap: got %b required 1", tx);
        end
        if (exp_q.size() == 0) break;
        @(negedge clk);
        vectors++;
        if (tx !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL back_to_back_start: got %b required 0", tx);
          break;
        end
      end
    end
  end

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    logic exp_mw;
    exp_mw       = (a != 8'hF0) && (a != 8'hF1);
    data_address = a;
    ram_out      = d;
    write        = 1'b1;
    #1;
    vectors++;
    if (mem_write !== exp_mw) begin
      miscompares++;
      $display("[TB] FAIL mem_write@%h: got %b required %b", a, mem_write, exp_mw);
    end
    @(negedge clk);
    write        = 1'b0;
    data_address = 8'h00;
  endtask

  task automatic read_status(output logic [7:0] s);
    data_address = 8'hF1;
    #1;
    s            = ram_in;
    data_address = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0] s;
    rst = 1'b1; kd_reset = 1'b0; write = 1'b0;
    data_address = 8'h10; ram_out = 8'h00; mem_rdata = 8'h5A;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (ram_in !== 8'h5A) begin
      miscompares++;
      $display("[TB] FAIL reset_passthru: got %h required 5a", ram_in);
    end
    vectors++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_tx: got tx=%b busy=%b required 1/0", tx, tx_busy);
    end
    read_status(s);
    vectors++;
    if (s !== 8'h01) begin
      miscompares++;
      $display("[TB] FAIL reset_status: got %h required 01", s);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    bus_write(8'h10, 8'h3C);
    #1;
    vectors++;
    if (mem_write !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mem_write_release: got %b required 0", mem_write);
    end
    data_address = 8'h10; mem_rdata = 8'h99;
    #1;
    vectors++;
    if (ram_in !== 8'h99) begin
      miscompares++;
      $display("[TB] FAIL ram_read: got %h required 99", ram_in);
    end
    data_address = 8'hF0;
    #1;
    vectors++;
    if (ram_in !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL tx_addr_read: got %h required 00", ram_in);
    end
    data_address = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [7:0] b;
    logic       exp_tx;
    b = 8'hA5;
    exp_q.push_back(b);
    bus_write(8'hF0, b);
    vectors++;
    if (tx !== 1'b1 || tx_busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL push_latency: got tx=%b busy=%b required 1/1", tx, tx_busy);
    end
    for (int k = 1; k <= 10 * CPB; k++) begin
      @(negedge clk);
      if (k <= CPB)           exp_tx = 1'b0;
      else if (k <= 9 * CPB)  exp_tx = b[(k - CPB - 1) / CPB];
      else                    exp_tx = 1'b1;
      vectors++;
      if (tx !== exp_tx) begin
        miscompares++;
        $display("[TB] FAIL wave_cycle_%0d: got %b required %b", k, tx, exp_tx);
      end
    end
    @(negedge clk);
    vectors++;
    if (tx_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_after_frame: got %b required 0", tx_busy);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fill_overflow();
    logic [7:0] s;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) exp_q.push_back(8'(i));
      bus_write(8'hF0, 8'(i));
    end
    read_status(s);
    vectors++;
    if (s !== 8'h4E) begin
      miscompares++;
      $display("[TB] FAIL status_overflow: got %h required 4e", s);
    end
    bus_write(8'hF1, 8'h00);
    read_status(s);
    vectors++;
    if (s !== 8'h46) begin
      miscompares++;
      $display("[TB] FAIL status_ovf_clear: got %h required 46", s);
    end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] s;
    bit         found;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      read_status(s);
      if (!s[2]) begin
        found = 1'b1;
        vectors++;
        if (s !== 8'h42) begin
          miscompares++;
          $display("[TB] FAIL status_idle_full: got %h required 42", s);
        end
        exp_q.push_back(8'h77);
        bus_write(8'hF0, 8'h77);
        read_status(s);
        vectors++;
        if (s !== 8'h46) begin
          miscompares++;
          $display("[TB] FAIL push_pop_full: got %h required 46", s);
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL idle_window_timeout: got none required idle cycle");
    end
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tx_busy) break;
    end
    vectors++;
    if (exp_q.size() != 0 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL drain: got pending=%0d busy=%b required 0/0", exp_q.size(), tx_busy);
    end
    read_status(s);
    vectors++;
    if (s !== 8'h01) begin
      miscompares++;
      $display("[TB] FAIL status_drained: got %h required 01", s);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_kd_reset();
    logic [7:0] s;
    bit         went_low;
    mon_en = 1'b0;
    bus_write(8'hF0, 8'hC3);
    bus_write(8'hF0, 8'h3C);
    bus_write(8'hF0, 8'h81);
    repeat (16) @(negedge clk);
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL data_bit3: got %b required 0", tx);
    end
    kd_reset = 1'b1; write = 1'b1; data_address = 8'hF0; ram_out = 8'hEE;
    @(negedge clk);
    kd_reset = 1'b0; write = 1'b0; data_address = 8'h00;
    vectors++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL kd_reset_tx: got tx=%b busy=%b required 1/0", tx, tx_busy);
    end
    read_status(s);
    vectors++;
    if (s !== 8'h01) begin
      miscompares++;
      $display("[TB] FAIL kd_reset_status: got %h required 01", s);
    end
    went_low = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) went_low = 1'b1;
    end
    vectors++;
    if (went_low) begin
      miscompares++;
      $display("[TB] FAIL kd_reset_quiet: got activity required idle line");
    end
    mon_en = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [7:0] s;
    bit         went_low;
    mon_en = 1'b0;
    bus_write(8'hF0, 8'h5A);
    bus_write(8'hF0, 8'h11);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_tx: got tx=%b busy=%b required 1/0", tx, tx_busy);
    end
    read_status(s);
    vectors++;
    if (s !== 8'h01) begin
      miscompares++;
      $display("[TB] FAIL async_reset_status: got %h required 01", s);
    end
    @(negedge clk);
    rst = 1'b0;
    went_low = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) went_low = 1'b1;
    end
    vectors++;
    if (went_low) begin
      miscompares++;
      $display("[TB] FAIL async_reset_quiet: got activity required idle line");
    end
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_single_byte();
    test_fill_overflow();
    test_push_pop_full();
    test_kd_reset();
    test_async_reset();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL leftover_expected: got %0d required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kt8_uart_tx_port.md
Name: kt8_uart_tx_port

Overview:
Data-side neighbour of the kt8 CPU. It decodes the CPU's data_address, write and ram_out signals and routes them either to the external data RAM or to a memory-mapped serial transmit port. The port is a small TX FIFO feeding an 8N1 UART transmitter. The block also drives the CPU's ram_in read-data bus, muxing RAM read data with a status register.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2.
FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2 and <= 4.
TX_ADDR, 8'hF0, write-only address of the TX data register.
STAT_ADDR, 8'hF1, address of the status register; a read returns status, a write clears overflow.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
data_address  input  8  CPU data address
ram_out  input  8  CPU write data
write  input  1  CPU write strobe; one write per asserted cycle
kd_reset  input  1  synchronous soft clear of the port
mem_rdata  input  8  read data from the external data RAM
ram_in  output  8  read data to the CPU (combinational)
mem_write  output  1  write strobe to the data RAM
tx  output  1  serial line; idles high
tx_busy  output  1  high while a frame is in flight or the FIFO is non-empty

Behaviour:
- Decode (combinational):
  - io_sel = (data_address == TX_ADDR) || (data_address == STAT_ADDR).
  - mem_write = write && !io_sel. RAM never sees I/O writes.
  - ram_in = status when data_address == STAT_ADDR; 8'h00 when data_address == TX_ADDR; otherwise mem_rdata.
- Status byte:
  - bit0 fifo_empty, bit1 fifo_full, bit2 tx_active (FSM not IDLE), bit3 overflow.
  - bits6:4 fifo_count (0..FIFO_DEPTH), bit7 = 0.
- Push: write && data_address == TX_ADDR pushes ram_out.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and overflow sets (sticky).
  - Push and pop in the same cycle: both take effect, count unchanged. This includes the full case: the push is accepted and overflow is not set.
- Overflow clear: write && data_address == STAT_ADDR clears overflow, whatever the data value. If a drop happens in the same cycle, overflow remains set.
- FIFO: circular buffer with read/write pointers that wrap modulo FIFO_DEPTH, plus a count register. Data goes out in push order.
- TX FSM states: IDLE, START, DATA, STOP. It uses a bit-period counter (0..CLKS_PER_BIT-1), a 3-bit bit index and an 8-bit shift register.
  - IDLE: tx = 1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0] (LSB first) for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit 7 go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles, then go to IDLE.
  - Back-to-back frames have exactly one IDLE cycle between the end of STOP and the next start bit.
- Latency: a push at edge N makes count 1. The FSM pops at edge N+1, so tx falls after edge N+1 (given the FSM was idle).
- Frame length: 10*CLKS_PER_BIT cycles of tx activity.
- tx is a registered output; no glitches.
- tx_busy = (state != IDLE) || (count != 0).
- rst (asynchronous): FIFO emptied, pointers and count = 0, overflow = 0, state = IDLE, tx = 1, counters = 0. ram_in and mem_write follow their inputs combinationally.
- kd_reset (synchronous, sampled at the edge): same effect as rst. An in-flight frame is aborted and tx returns high the next cycle. kd_reset has priority over a push in the same cycle.
- Reset mid-frame: the partial frame is lost; no resume.

Decomposition:
- Shared kt8 package: TX_ADDR/STAT_ADDR defaults, status bit-index constants, and TX FSM state encodings (2-bit localparams).
- One sub-module: kt8_byte_fifo (push, pop, din, dout, count, full, empty, clear), instantiated once.
- Address decode and the TX FSM stay in the top module.

Test Plan:
- Reset: assert rst mid-simulation asynchronously -> tx = 1, status read at 8'hF1 returns 8'h01, tx_busy = 0.
- Single byte: CLKS_PER_BIT=4; write 8'hA5 to 8'hF0 -> tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles. Total 40 cycles. mem_write stays 0.
- Fill/overflow: write 6 bytes 8'h01..8'h06 back-to-back. The first is popped one cycle after it is written, so bytes 8'h01..8'h05 are accepted and 8'h06 is dropped -> status = 8'h4E (count 4, full, active, overflow). Writing 8'h00 to 8'hF1 -> bit3 clears. Serial output is 01,02,03,04,05 in order, each frame separated by one idle cycle.
- Simultaneous push/pop at full: FIFO full with the FSM entering IDLE, push 8'h77 on the pop cycle -> accepted, no overflow, 8'h77 transmitted last.
- Pass-through: write 8'h3C to 8'h10 -> mem_write = 1 that cycle. Read address 8'h10 with mem_rdata = 8'h99 -> ram_in = 8'h99. Read 8'hF0 -> ram_in = 8'h00.
- kd_reset mid-frame: pulse kd_reset during DATA bit 3 with 2 bytes queued -> next cycle tx = 1, status = 8'h01, no further frames.
